// File: rtl/leb128_reader.sv
// Byte-serial LEB128 decoder: fetches one encoded u32/i32 through a byte-wide
// read handshake and returns the value, encoded length and following address.
module leb128_reader #(
  parameter int MAX_BYTES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic        is_signed,
  output logic [31:0] mem_addr,
  output logic        mem_read_en,
  input  logic [7:0]  mem_data_out,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] value,
  output logic [2:0]  byte_count,
  output logic [31:0] next_addr,
  output logic        error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic        sgn;
  logic [31:0] acc;
  logic [5:0]  sh;
  logic [2:0]  cnt;

  logic [7:0]  b;
  logic [38:0] part;
  logic [31:0] acc_n;
  logic [5:0]  sh_n;
  logic [31:0] ext;
  logic        last;
  logic        bad;
  logic        term;

  always_comb begin
    b     = mem_data_out;
    part  = {32'd0, b[6:0]} << sh;
    acc_n = acc | part[31:0];
    sh_n  = sh + 6'd7;
    last  = (cnt == 3'(MAX_BYTES - 1));
    // final byte may only carry the bits that still fit (or, signed, their sign copies)
    bad   = last && (b[7] || (sgn ? (b[6:4] != {3{b[3]}}) : (b[6:4] != 3'b000)));
    term  = !b[7] || last;
    ext   = (sgn && b[6] && (sh_n < 6'd32)) ? (32'hFFFF_FFFF << sh_n) : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sgn         <= 1'b0;
      acc         <= 32'd0;
      sh          <= 6'd0;
      cnt         <= 3'd0;
      mem_addr    <= 32'd0;
      mem_read_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      value       <= 32'd0;
      byte_count  <= 3'd0;
      next_addr   <= 32'd0;
      error       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mem_addr    <= start_addr;
            sgn         <= is_signed;
            acc         <= 32'd0;
            sh          <= 6'd0;
            cnt         <= 3'd0;
            busy        <= 1'b1;
            mem_read_en <= 1'b1;
            state       <= S_READ;
          end
        end
        S_READ: begin
          if (mem_ready) begin
            mem_read_en <= 1'b0;
            acc         <= acc_n;
            sh          <= sh_n;
            cnt         <= cnt + 3'd1;
            mem_addr    <= mem_addr + 32'd1;
            if (term) begin
              state      <= S_DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              value      <= bad ? 32'd0 : (acc_n | ext);
              byte_count <= cnt + 3'd1;
              next_addr  <= mem_addr + 32'd1;
              error      <= bad;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          mem_read_en <= 1'b1;
          state       <= S_READ;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
